// File: rtl/sysctrl_pkg.sv
// Shared types and default register map for the sysctrl boot master.
package sysctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_POLL,
    S_GAP,
    S_WR_CLK,
    S_WR_TRAP,
    S_WR_IRQ,
    S_VFY_CLK,
    S_VFY_TRAP,
    S_VFY_IRQ,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_PWR  = 2'd1,
    ERR_BUS  = 2'd2,
    ERR_VFY  = 2'd3
  } err_code_t;

  localparam logic [7:0] DEF_PWRGOOD  = 8'h00;
  localparam logic [7:0] DEF_CLK_OUT  = 8'h04;
  localparam logic [7:0] DEF_TRAP_OUT = 8'h08;
  localparam logic [7:0] DEF_IRQ_SRC  = 8'h0c;

  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [7:0] ofs);
    return {base[31:8], ofs};
  endfunction

endpackage

// File: rtl/sysctrl_boot_xfer.sv
// Single-transfer iomem engine: registers the request, waits for ready, and
// reports completion (ack) or a bus timeout (tmo) as one-cycle pulses.
module sysctrl_boot_xfer #(
  parameter logic [7:0] BUS_TMO = 8'd63
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        tmo,
  output logic [31:0] iomem_addr,
  output logic        iomem_valid,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  input  logic        iomem_ready
);

  logic [7:0] bus_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      iomem_valid <= 1'b0;
      iomem_addr  <= '0;
      iomem_wstrb <= '0;
      iomem_wdata <= '0;
      rdata       <= '0;
      ack         <= 1'b0;
      tmo         <= 1'b0;
      bus_cnt     <= '0;
    end else begin
      ack <= 1'b0;
      tmo <= 1'b0;
      if (iomem_valid) begin
        if (iomem_ready) begin
          iomem_valid <= 1'b0;
          ack         <= 1'b1;
          rdata       <= iomem_rdata;
          bus_cnt     <= '0;
        end else if (({1'b0, bus_cnt} + 9'd1) >= {1'b0, BUS_TMO}) begin
          iomem_valid <= 1'b0;
          tmo         <= 1'b1;
          bus_cnt     <= '0;
        end else begin
          bus_cnt <= bus_cnt + 8'd1;
        end
      end else if (req && !ack && !tmo) begin
        // req is still asserted by the old state during the ack/tmo cycle
        iomem_valid <= 1'b1;
        iomem_addr  <= addr;
        iomem_wstrb <= wstrb;
        iomem_wdata <= wdata;
      end
    end
  end

endmodule

// File: rtl/sysctrl_boot_master.sv
// Boot sequencer for the sysctrl block: polls PWRGOOD, writes the output
// configuration words, optionally verifies them (SYSCTRL_BOOT_VERIFY_EN).
module sysctrl_boot_master
  import sysctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADR   = 32'h2300_0000,
  parameter logic [7:0]  PWRGOOD    = DEF_PWRGOOD,
  parameter logic [7:0]  CLK_OUT    = DEF_CLK_OUT,
  parameter logic [7:0]  TRAP_OUT   = DEF_TRAP_OUT,
  parameter logic [7:0]  IRQ_SRC    = DEF_IRQ_SRC,
  parameter logic [3:0]  PWR_MASK   = 4'hF,
  parameter logic [1:0]  CLK_CFG    = 2'b00,
  parameter logic        TRAP_CFG   = 1'b0,
  parameter logic [1:0]  IRQ_CFG    = 2'b00,
  parameter logic [7:0]  POLL_MAX   = 8'd255,
  parameter logic [15:0] POLL_GAP   = 16'd1000,
  parameter logic [7:0]  BUS_TMO    = 8'd63,
  parameter logic        AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic [31:0] iomem_addr,
  output logic        iomem_valid,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  input  logic        iomem_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  state_t      state, next_state;
  err_code_t   fail_code;
  logic [7:0]  poll_cnt;
  logic [15:0] gap_cnt;
  logic        auto_armed;
  logic        go, rest, pwr_ok, poll_last;
  logic        xreq, xack, xtmo;
  logic [31:0] xaddr, xwdata, xrdata;
  logic [3:0]  xwstrb;
  logic        unused_rdata;

  assign unused_rdata = ^xrdata[31:4];

  sysctrl_boot_xfer #(.BUS_TMO(BUS_TMO)) u_xfer (
    .clk         (clk),
    .resetn      (resetn),
    .req         (xreq),
    .addr        (xaddr),
    .wstrb       (xwstrb),
    .wdata       (xwdata),
    .ack         (xack),
    .rdata       (xrdata),
    .tmo         (xtmo),
    .iomem_addr  (iomem_addr),
    .iomem_valid (iomem_valid),
    .iomem_wstrb (iomem_wstrb),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .iomem_ready (iomem_ready)
  );

  assign rest      = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign go        = rest && (start || ((state == S_IDLE) && auto_armed && AUTO_START));
  assign pwr_ok    = ((xrdata[3:0] & PWR_MASK) == PWR_MASK);
  assign poll_last = ({1'b0, poll_cnt} + 9'd1) >= {1'b0, POLL_MAX};

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    fail_code  = ERR_NONE;
    if (xtmo) begin
      next_state = S_ERR;
      fail_code  = ERR_BUS;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: if (go) next_state = S_POLL;
        S_POLL: if (xack) begin
          if (pwr_ok) next_state = S_WR_CLK;
          else if (poll_last) begin
            next_state = S_ERR;
            fail_code  = ERR_PWR;
          end else if (POLL_GAP == 16'd0) next_state = S_POLL;
          else next_state = S_GAP;
        end
        S_GAP:     if (({1'b0, gap_cnt} + 17'd1) >= {1'b0, POLL_GAP}) next_state = S_POLL;
        S_WR_CLK:  if (xack) next_state = S_WR_TRAP;
        S_WR_TRAP: if (xack) next_state = S_WR_IRQ;
`ifdef SYSCTRL_BOOT_VERIFY_EN
        S_WR_IRQ:  if (xack) next_state = S_VFY_CLK;
        S_VFY_CLK: if (xack) begin
          if (xrdata[1:0] != CLK_CFG) begin
            next_state = S_ERR;
            fail_code  = ERR_VFY;
          end else next_state = S_VFY_TRAP;
        end
        S_VFY_TRAP: if (xack) begin
          if (xrdata[0] != TRAP_CFG) begin
            next_state = S_ERR;
            fail_code  = ERR_VFY;
          end else next_state = S_VFY_IRQ;
        end
        S_VFY_IRQ: if (xack) begin
          if (xrdata[1:0] != IRQ_CFG) begin
            next_state = S_ERR;
            fail_code  = ERR_VFY;
          end else next_state = S_DONE;
        end
`else
        S_WR_IRQ:  if (xack) next_state = S_DONE;
`endif
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    xreq   = 1'b0;
    xaddr  = '0;
    xwstrb = '0;
    xwdata = '0;
    case (state)
      S_POLL: begin
        xreq  = 1'b1;
        xaddr = reg_addr(BASE_ADR, PWRGOOD);
      end
      S_WR_CLK: begin
        xreq   = 1'b1;
        xaddr  = reg_addr(BASE_ADR, CLK_OUT);
        xwstrb = 4'h1;
        xwdata = {30'd0, CLK_CFG};
      end
      S_WR_TRAP: begin
        xreq   = 1'b1;
        xaddr  = reg_addr(BASE_ADR, TRAP_OUT);
        xwstrb = 4'h1;
        xwdata = {31'd0, TRAP_CFG};
      end
      S_WR_IRQ: begin
        xreq   = 1'b1;
        xaddr  = reg_addr(BASE_ADR, IRQ_SRC);
        xwstrb = 4'h1;
        xwdata = {30'd0, IRQ_CFG};
      end
      S_VFY_CLK: begin
        xreq  = 1'b1;
        xaddr = reg_addr(BASE_ADR, CLK_OUT);
      end
      S_VFY_TRAP: begin
        xreq  = 1'b1;
        xaddr = reg_addr(BASE_ADR, TRAP_OUT);
      end
      S_VFY_IRQ: begin
        xreq  = 1'b1;
        xaddr = reg_addr(BASE_ADR, IRQ_SRC);
      end
      default: ;
    endcase
  end

  // Status flags are registered from next_state so they change on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      poll_cnt   <= '0;
      gap_cnt    <= '0;
      auto_armed <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= '0;
    end else begin
      auto_armed <= 1'b0;
      busy  <= !((next_state == S_IDLE) || (next_state == S_DONE) || (next_state == S_ERR));
      done  <= (next_state == S_DONE);
      error <= (next_state == S_ERR);
      if (go) err_code <= '0;
      else if ((next_state == S_ERR) && (state != S_ERR)) err_code <= fail_code;
      if (go) poll_cnt <= '0;
      else if ((state == S_POLL) && xack && !pwr_ok && (poll_cnt != 8'hFF))
        poll_cnt <= poll_cnt + 8'd1;
      if ((state == S_GAP) && (next_state == S_GAP)) gap_cnt <= gap_cnt + 16'd1;
      else gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_sysctrl_boot_master.sv
// Randomized directed bench for sysctrl_boot_master with a transaction-level reference model.
module tb_sysctrl_boot_master;

  localparam logic [31:0] BASE = 32'h2300_0000;
  localparam int          PMAX = 5;
  localparam int          PGAP = 10;
  localparam int          TMO  = 63;
  localparam logic [1:0]  CCFG = 2'b11;
  localparam logic        TCFG = 1'b1;
  localparam logic [1:0]  ICFG = 2'b10;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } txn_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] iomem_addr;
  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata = '0;
  logic        iomem_ready = 1'b0;
  logic        busy, done, error;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  logic        hang = 1'b0;
  logic        corrupt = 1'b0;
  int          lat = 0, lat_cnt = 0;
  int          nfail = 0, pg_reads = 0;
  int          hi_run = 0, lo_run = 0, last_hi = 0, min_gap = 999;
  logic [31:0] fail_vals[16];
  logic [31:0] mem[4];
  txn_t        log_q[$];
  txn_t        exp_q[$];
  logic        exp_done;
  logic [1:0]  exp_code;
  int          exp_reads;

  sysctrl_boot_master #(
    .BASE_ADR (BASE),
    .CLK_CFG  (CCFG),
    .TRAP_CFG (TCFG),
    .IRQ_CFG  (ICFG),
    .POLL_MAX (8'(PMAX)),
    .POLL_GAP (16'(PGAP)),
    .BUS_TMO  (8'(TMO))
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .iomem_addr  (iomem_addr),
    .iomem_valid (iomem_valid),
    .iomem_wstrb (iomem_wstrb),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .iomem_ready (iomem_ready),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  // Responder with random ack latency, plus a monitor of valid high/low run lengths.
  always @(posedge clk) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      lat_cnt = 0;
      hi_run  = 0;
      lo_run  = 0;
    end else begin
      if (iomem_valid) begin
        if (hi_run == 0 && iomem_addr == BASE && pg_reads > 0 && lo_run < min_gap) min_gap = lo_run;
        hi_run++;
        lo_run = 0;
      end else begin
        if (hi_run > 0) last_hi = hi_run;
        hi_run = 0;
        lo_run++;
      end
      if (iomem_ready) begin
        iomem_ready <= 1'b0;
        if (iomem_valid) begin
          log_q.push_back('{iomem_addr, iomem_wstrb, (iomem_wstrb != 4'h0) ? iomem_wdata : 32'h0});
          if (iomem_wstrb != 4'h0) mem[iomem_addr[3:2]] = iomem_wdata;
        end
      end else if (iomem_valid && !hang) begin
        if (lat_cnt >= lat) begin
          lat_cnt = 0;
          iomem_ready <= 1'b1;
          if (iomem_addr == BASE) begin
            iomem_rdata <= (pg_reads < nfail && pg_reads < 16) ? fail_vals[pg_reads]
                                                             : {$urandom, 4'hF};
            pg_reads++;
          end else if (corrupt && iomem_addr[3:2] == 2'd1) begin
            iomem_rdata <= {mem[1][31:2], 2'b01};
          end else begin
            iomem_rdata <= mem[iomem_addr[3:2]];
          end
        end else lat_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: expected bus transactions and final status for a run with nf failing polls.
  task automatic build_exp(input int nf, input bit corr);
    exp_q.delete();
    exp_reads = (nf >= PMAX) ? PMAX : nf + 1;
    for (int i = 0; i < exp_reads; i++) exp_q.push_back('{BASE, 4'h0, 32'h0});
    if (nf >= PMAX) begin
      exp_done = 1'b0;
      exp_code = 2'd1;
      return;
    end
    exp_q.push_back('{BASE + 32'h4, 4'h1, {30'd0, CCFG}});
    exp_q.push_back('{BASE + 32'h8, 4'h1, {31'd0, TCFG}});
    exp_q.push_back('{BASE + 32'hc, 4'h1, {30'd0, ICFG}});
    exp_done = 1'b1;
    exp_code = 2'd0;
`ifdef SYSCTRL_BOOT_VERIFY_EN
    exp_q.push_back('{BASE + 32'h4, 4'h0, 32'h0});
    if (corr) begin
      exp_done = 1'b0;
      exp_code = 2'd3;
      return;
    end
    exp_q.push_back('{BASE + 32'h8, 4'h0, 32'h0});
    exp_q.push_back('{BASE + 32'hc, 4'h0, 32'h0});
`else
    if (corr) exp_done = 1'b1;
`endif
  endtask

  task automatic prep(input int nf, input bit corr);
    nfail = nf;
    corrupt = corr;
    lat = $urandom_range(0, 4);
    for (int i = 0; i < 16; i++) fail_vals[i] = {$urandom, 4'($urandom_range(0, 14))};
    log_q.delete();
    pg_reads = 0;
    min_gap = 999;
    build_exp(nf, corr);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 20000; i++) begin
      if (done || error) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic finish_case(input string tag);
    wait_end();
    check({tag, "_ended"}, 68'(done | error), 68'd1);
    check({tag, "_done"}, 68'(done), 68'(exp_done));
    check({tag, "_error"}, 68'(error), 68'(!exp_done));
    check({tag, "_code"}, 68'(err_code), 68'(exp_code));
    check({tag, "_busy"}, 68'(busy), 68'd0);
    check({tag, "_ntxn"}, 68'(log_q.size()), 68'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_txn%0d", tag, i), log_q[i], exp_q[i]);
    if (exp_reads > 1) check({tag, "_gap"}, 68'(min_gap >= PGAP), 68'd1);
  endtask

  initial begin
    mem[0] = '0; mem[1] = '0; mem[2] = '0; mem[3] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 68'(iomem_valid), 68'd0);
    check("rst_addr", 68'(iomem_addr), 68'd0);
    check("rst_wstrb", 68'(iomem_wstrb), 68'd0);
    check("rst_wdata", 68'(iomem_wdata), 68'd0);
    check("rst_flags", 68'({busy, done, error, err_code}), 68'd0);

    // T1: auto start, power already good
    prep(0, 1'b0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("t1_busy_rise", 68'(busy), 68'd1);
    finish_case("t1");

    // T2: three failing polls with the gap enforced
    prep(3, 1'b0);
    pulse_start();
    check("t2_busy", 68'(busy), 68'd1);
    check("t2_done_clr", 68'(done), 68'd0);
    finish_case("t2");

    // T3: power never good, stuck at zero
    prep(99, 1'b0);
    for (int i = 0; i < 16; i++) fail_vals[i] = '0;
    pulse_start();
    finish_case("t3");

    // start while busy is ignored
    prep(2, 1'b0);
    pulse_start();
    repeat (8) @(posedge clk);
    #1 pulse_start();
    finish_case("busy_start");

    for (int r = 0; r < 5; r++) begin
      prep($urandom_range(0, 6), 1'b0);
      pulse_start();
      finish_case($sformatf("rnd%0d", r));
    end

    // T4: responder never acks
    prep(0, 1'b0);
    hang = 1'b1;
    last_hi = 0;
    pulse_start();
    wait_end();
    check("t4_error", 68'(error), 68'd1);
    check("t4_code", 68'(err_code), 68'd2);
    check("t4_busy", 68'(busy), 68'd0);
    check("t4_valid_len", 68'(last_hi), 68'(TMO));
    check("t4_ntxn", 68'(log_q.size()), 68'd0);
    hang = 1'b0;

    // T5: reset while the TRAP_OUT write is on the bus
    prep(0, 1'b0);
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      if (iomem_valid && iomem_addr == BASE + 32'h8) break;
      @(posedge clk);
      #1;
    end
    check("t5_reached_trap", 68'(iomem_valid && iomem_addr == BASE + 32'h8), 68'd1);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("t5_valid", 68'(iomem_valid), 68'd0);
    check("t5_bus", 68'({iomem_addr, iomem_wstrb, iomem_wdata}), 68'd0);
    check("t5_flags", 68'({busy, done, error, err_code}), 68'd0);
    prep(1, 1'b0);
    resetn = 1'b1;
    finish_case("t5_rerun");

`ifdef SYSCTRL_BOOT_VERIFY_EN
    // T6: read-back mismatch on CLK_OUT, then a clean rerun
    prep(0, 1'b1);
    pulse_start();
    finish_case("t6_bad");
    prep(0, 1'b0);
    pulse_start();
    check("t6_err_clr", 68'({error, err_code}), 68'd0);
    finish_case("t6_rerun");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
